// File: rtl/ps2_host_tx_if.sv
// Bus bundle for the PS/2 host transmitter.
// master: the command issuer plus the pad side (drives data/send and the pad readbacks).
// slave:  the transmitter (drives busy/done/error and the two open-collector enables).
//   data      8  byte to send
//   send      1  one-cycle start strobe
//   busy      1  transfer in progress
//   done      1  one-cycle pulse, byte sent and ACKed
//   error     1  one-cycle pulse, timeout or missing ACK
//   ps2clk_in 1  pad value of the PS/2 clock
//   ps2dat_in 1  pad value of the PS/2 data line
//   ps2clk_oe 1  1 = pull clock pad low
//   ps2dat_oe 1  1 = pull data pad low
interface ps2_host_tx_if;
  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       done;
  logic       error;
  logic       ps2clk_in;
  logic       ps2dat_in;
  logic       ps2clk_oe;
  logic       ps2dat_oe;

  modport master (
    output data, send, ps2clk_in, ps2dat_in,
    input  busy, done, error, ps2clk_oe, ps2dat_oe
  );

  modport slave (
    input  data, send, ps2clk_in, ps2dat_in,
    output busy, done, error, ps2clk_oe, ps2dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over the shared
// open-collector clock/data pads. Pads are only ever pulled low.
// Ports:
//   sysclk  system clock, the only clock
//   rst     asynchronous reset, active high
//   bus     ps2_host_tx_if.slave (data/send in, busy/done/error out, pad in/oe out)
module ps2_host_tx #(
  parameter int unsigned CLKFREQ    = 28000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input logic           sysclk,
  input logic           rst,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned NINH   = CLKFREQ / 1000000 * INHIBIT_US;
  localparam int unsigned NTO    = CLKFREQ / 1000 * TIMEOUT_MS;
  localparam int unsigned CntMax = (NTO > NINH) ? NTO : NINH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StRts, StShift, StAck, StWaitIdle, StFail
  } state_e;

  // Pad synchronisers; reset to 1 (released line) so no false fall after reset.
  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_prev_q;
  logic       clk_s, dat_s, fall;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2clk_in};
      dat_sync_q <= {dat_sync_q[0], bus.ps2dat_in};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_prev_q & ~clk_s;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [9:0]     sr_q, sr_d;
  logic           ack_q, ack_d;
  logic           clk_oe_q, clk_oe_d;
  logic           dat_oe_q, dat_oe_d;
  logic           done_c;
  logic           timeout;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      sr_q     <= '0;
      ack_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      ack_q    <= ack_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  // cnt_q counts cycles since the clock was released; this is the NTO-th cycle.
  assign timeout = (cnt_q == CntW'(NTO - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    ack_d    = ack_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_c   = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (bus.send) begin
          sr_d     = {1'b1, ~^bus.data, bus.data};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == CntW'(NINH - 1)) begin
          dat_oe_d = 1'b1;  // start bit
          state_d  = StRts;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRts: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        bitcnt_d = '0;
        state_d  = StShift;
      end
      StShift: begin
        cnt_d = cnt_q + CntW'(1);
        if (timeout) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = StFail;
        end else if (fall) begin
          if (bitcnt_q < 4'd10) begin
            dat_oe_d = ~sr_q[bitcnt_q];
            bitcnt_d = bitcnt_q + 4'd1;
          end else begin
            ack_d   = dat_s;  // device must hold data low at the 11th fall
            state_d = StAck;
          end
        end
      end
      StAck: begin
        cnt_d = cnt_q + CntW'(1);
        if (timeout || ack_q) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = StFail;
        end else begin
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        cnt_d = cnt_q + CntW'(1);
        if (timeout) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = StFail;
        end else if (clk_s && dat_s) begin
          done_c  = 1'b1;
          state_d = StIdle;
        end
      end
      StFail: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_c;
  assign bus.error     = (state_q == StFail);
  assign bus.ps2clk_oe = clk_oe_q;
  assign bus.ps2dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on pull-up pads plus a per-cycle
// timeline checker. Runs at 1 MHz sysclk so NINH = 100 and NTO = 15000.
module tb_ps2_host_tx;
  localparam int NINH = 100;    // 1 MHz / 1e6 * 100 us
  localparam int NTO  = 15000;  // 1 MHz / 1e3 * 15 ms
  localparam int HALF = 40;     // half period of a 12.5 kHz device clock

  logic sysclk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic pad_clk, pad_dat;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_err = 0;
  int frame_k = 0;
  bit frame_on = 1'b0;
  bit tmo_mode = 1'b0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .CLKFREQ    (1000000),
    .INHIBIT_US (100),
    .TIMEOUT_MS (15)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  assign pad_clk = ~bus.ps2clk_oe & ~dev_clk_low;
  assign pad_dat = ~bus.ps2dat_oe & ~dev_dat_low;
  assign bus.ps2clk_in = pad_clk;
  assign bus.ps2dat_in = pad_dat;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Frame in send order: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Per-cycle compare against the expected timeline of the current transfer.
  always @(negedge sysclk) begin
    if (!rst) begin
      chk("done_and_error", 32'(bus.done & bus.error), 32'd0);
      if (!bus.busy) chk("idle_pads", 32'({bus.ps2clk_oe, bus.ps2dat_oe}), 32'd0);
      if (frame_on) begin
        frame_k++;
        if (bus.done) n_done++;
        if (bus.error) n_err++;
        if (frame_k <= NINH)
          chk("inhibit", 32'({bus.busy, bus.ps2clk_oe, bus.ps2dat_oe}), 32'b110);
        else if (frame_k == NINH + 1)
          chk("rts", 32'({bus.busy, bus.ps2clk_oe, bus.ps2dat_oe}), 32'b111);
        else if (frame_k == NINH + 2)
          chk("release", 32'({bus.busy, bus.ps2clk_oe, bus.ps2dat_oe}), 32'b101);
        if (tmo_mode) begin
          if (frame_k < NINH + 2 + NTO)
            chk("tmo_wait", 32'({bus.busy, bus.error}), 32'b10);
          else if (frame_k == NINH + 2 + NTO)
            chk("tmo_error", 32'({bus.error, bus.ps2clk_oe, bus.ps2dat_oe, bus.done}), 32'b1000);
        end
      end else begin
        chk("idle", 32'({bus.busy, bus.done, bus.error, bus.ps2clk_oe, bus.ps2dat_oe}), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(posedge sysclk); #1;
    bus.data = d;
    bus.send = 1'b1;
    @(posedge sysclk); #1;
    bus.send = 1'b0;
    frame_k  = 0;
    n_done   = 0;
    n_err    = 0;
    frame_on = 1'b1;
  endtask

  // Device: waits for request-to-send, reads the start bit, then clocks nclk
  // times sampling on each rise. Optionally ACKs, re-strobes send, or resets.
  task automatic device_run(input int nclk, input bit do_ack, input int resend_at,
                            input int rst_at, output logic [10:0] got);
    int t;
    got = '0;
    t = 0;
    while (!(pad_clk && !pad_dat) && t < 4 * NINH) begin
      cyc(1);
      t++;
    end
    chk("rts_seen", 32'(t < 4 * NINH), 32'd1);
    cyc(HALF / 2);
    got[0] = pad_dat;
    for (int i = 1; i <= nclk; i++) begin
      cyc(HALF);
      dev_clk_low = 1'b1;
      if (i == rst_at) begin
        cyc(HALF / 2);
        @(negedge sysclk);
        #2;
        rst = 1'b1;
        frame_on = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_clk_oe", 32'(bus.ps2clk_oe), 32'd0);
        chk("rst_dat_oe", 32'(bus.ps2dat_oe), 32'd0);
        dev_clk_low = 1'b0;
        cyc(2);
        rst = 1'b0;
        return;
      end
      if (i == resend_at) begin
        bus.data = 8'h00;
        bus.send = 1'b1;
        cyc(1);
        bus.send = 1'b0;
        cyc(HALF - 1);
      end else begin
        cyc(HALF);
      end
      dev_clk_low = 1'b0;
      if (i <= 10) got[i] = pad_dat;
      if (i == 10 && do_ack) dev_dat_low = 1'b1;
      if (i == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int bound);
    int t;
    t = 0;
    while (n_done + n_err == 0 && t < bound) begin
      @(negedge sysclk);
      #1;
      t++;
    end
    chk("end_seen", 32'(t < bound), 32'd1);
    @(posedge sysclk); #1;
    frame_on = 1'b0;
  endtask

  task automatic run_ok(input logic [7:0] d, input logic [10:0] lit, input int resend_at);
    logic [10:0] got;
    send_byte(d);
    device_run(11, 1'b1, resend_at, 0, got);
    wait_end(300);
    chk("frame_model", 32'(got), 32'(model_frame(d)));
    chk("frame_literal", 32'(got), 32'(lit));
    chk("done_count", 32'(n_done), 32'd1);
    chk("error_count", 32'(n_err), 32'd0);
    cyc(20);
  endtask

  initial begin
    repeat (60000) @(posedge sysclk);
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion",
             n_checks);
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    bus.data = 8'h00;
    bus.send = 1'b0;
    cyc(3);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_error", 32'(bus.error), 32'd0);
    chk("reset_clk_oe", 32'(bus.ps2clk_oe), 32'd0);
    chk("reset_dat_oe", 32'(bus.ps2dat_oe), 32'd0);
    rst = 1'b0;
    cyc(5);

    // Normal frames; literals are {stop, parity, data, start}.
    run_ok(8'hED, 11'h7DA, 0);
    run_ok(8'hFF, 11'h7FE, 0);
    run_ok(8'h00, 11'h600, 0);
    run_ok(8'h01, 11'h402, 0);

    // Device never clocks: error exactly NTO cycles after the clock release.
    tmo_mode = 1'b1;
    send_byte(8'h12);
    device_run(0, 1'b0, 0, 0, got);
    chk("tmo_start_bit", 32'(got[0]), 32'd0);
    wait_end(NTO + 200);
    chk("tmo_done_count", 32'(n_done), 32'd0);
    chk("tmo_error_count", 32'(n_err), 32'd1);
    tmo_mode = 1'b0;
    cyc(20);

    // Device clocks 11 times but never ACKs.
    send_byte(8'hC3);
    device_run(11, 1'b0, 0, 0, got);
    wait_end(300);
    chk("nack_frame", 32'(got), 32'(model_frame(8'hC3)));
    chk("nack_done_count", 32'(n_done), 32'd0);
    chk("nack_error_count", 32'(n_err), 32'd1);
    cyc(20);

    // Strobe while busy is ignored.
    run_ok(8'h3C, 11'h678, 4);

    // Reset while bit 4 (a 0) is on the line, then a clean frame.
    send_byte(8'h4A);
    device_run(11, 1'b1, 0, 5, got);
    cyc(10);
    run_ok(8'hA5, 11'h74A, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
